// File: rtl/mod_counter.sv
// Up/down modulo-MODULUS counter with clear, clamped load, wrap/saturate end mode and sticky overflow.
// Latency: cnt/wrap/ovf_sticky 1 cycle; at_max/at_min combinational. Backpressure: none, en gates counting.
module mod_counter #(
    parameter int              N        = 8,
    parameter longint unsigned MODULUS  = 64'd1 << N,
    parameter bit              SATURATE = 1'b0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         en,
    input  logic         up,
    input  logic         clear,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         ovf_clr,
    output logic [N-1:0] cnt,
    output logic         at_max,
    output logic         at_min,
    output logic         wrap,
    output logic         ovf_sticky
);

    if (N < 2 || N > 32) begin : g_bad_n
        $error("mod_counter: N=%0d outside 2..32", N);
    end
    if (MODULUS < 2 || MODULUS > (64'd1 << N)) begin : g_bad_mod
        $error("mod_counter: MODULUS=%0d outside 2..2**N", MODULUS);
    end

    localparam logic [N-1:0] MAX_VAL = N'(MODULUS - 64'd1);

    logic [N-1:0] cnt_q, cnt_d;
    logic         wrap_q, wrap_d;
    logic         ovf_q, ovf_d;
    logic         end_hit;

    always_comb begin
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;
        end_hit = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        end else if (en) begin
            // End test precedes the step so cnt never leaves 0..MODULUS-1.
            if (up) begin
                if (cnt_q == MAX_VAL) begin
                    end_hit = 1'b1;
                    if (!SATURATE) begin
                        cnt_d  = '0;
                        wrap_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + N'(1);
                end
            end else begin
                if (cnt_q == '0) begin
                    end_hit = 1'b1;
                    if (!SATURATE) begin
                        cnt_d  = MAX_VAL;
                        wrap_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - N'(1);
                end
            end
        end
        // A set event beats a simultaneous clear request.
        ovf_d = end_hit | (ovf_q & ~ovf_clr);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
            ovf_q  <= ovf_d;
        end
    end

    assign cnt        = cnt_q;
    assign wrap       = wrap_q;
    assign ovf_sticky = ovf_q;
    assign at_max     = (cnt_q == MAX_VAL);
    assign at_min     = (cnt_q == '0);

endmodule

// File: tb/tb_mod_counter.sv
// Bench for mod_counter: vector table on a mod-10 wrap instance, hand sequences for
// saturate and mod-16 instances, then random stimulus against a behavioural model.
module tb_mod_counter;

    logic       clock = 1'b0;
    logic       reset, en, up, clear, load, ovf_clr;
    logic [3:0] load_val;

    logic [3:0] cnt_a, cnt_b, cnt_c;
    logic       max_a, max_b, max_c, min_a, min_b, min_c;
    logic       wrap_a, wrap_b, wrap_c, ovf_a, ovf_b, ovf_c;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clock = ~clock;

    mod_counter #(.N(4), .MODULUS(10), .SATURATE(1'b0)) u_wrap (
        .clock(clock), .reset(reset), .en(en), .up(up), .clear(clear), .load(load),
        .load_val(load_val), .ovf_clr(ovf_clr), .cnt(cnt_a), .at_max(max_a),
        .at_min(min_a), .wrap(wrap_a), .ovf_sticky(ovf_a));

    mod_counter #(.N(4), .MODULUS(10), .SATURATE(1'b1)) u_sat (
        .clock(clock), .reset(reset), .en(en), .up(up), .clear(clear), .load(load),
        .load_val(load_val), .ovf_clr(ovf_clr), .cnt(cnt_b), .at_max(max_b),
        .at_min(min_b), .wrap(wrap_b), .ovf_sticky(ovf_b));

    mod_counter #(.N(4), .MODULUS(16), .SATURATE(1'b0)) u_pow2 (
        .clock(clock), .reset(reset), .en(en), .up(up), .clear(clear), .load(load),
        .load_val(load_val), .ovf_clr(ovf_clr), .cnt(cnt_c), .at_max(max_c),
        .at_min(min_c), .wrap(wrap_c), .ovf_sticky(ovf_c));

    typedef struct {
        logic       rst, en, up, clr, ld;
        logic [3:0] lv;
        logic       oc;
        int         ec;
        logic       ew, eo;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, e, u, c, l, input int lv, input logic oc,
                       input int ec, input logic ew, eo);
        vec_t v;
        v.rst = r; v.en = e; v.up = u; v.clr = c; v.ld = l; v.lv = 4'(lv);
        v.oc = oc; v.ec = ec; v.ew = ew; v.eo = eo;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        else n_pass++;
    endtask

    task automatic drive(input logic r, e, u, c, l, input int lv, input logic oc);
        reset = r; en = e; up = u; clear = c; load = l; load_val = 4'(lv); ovf_clr = oc;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Behavioural model: one entry per instance.
    int modv[3] = '{10, 10, 16};
    bit satv[3] = '{1'b0, 1'b1, 1'b0};
    int m_cnt[3];
    bit m_wrap[3];
    bit m_ovf[3];

    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            bit hit;
            int nxt;
            hit = 1'b0;
            if (reset) begin
                m_cnt[i] = 0; m_wrap[i] = 1'b0; m_ovf[i] = 1'b0;
            end else begin
                m_wrap[i] = 1'b0;
                if (clear) m_cnt[i] = 0;
                else if (load) m_cnt[i] = (int'(load_val) < modv[i]) ? int'(load_val) : modv[i] - 1;
                else if (en) begin
                    nxt = up ? m_cnt[i] + 1 : m_cnt[i] - 1;
                    if (nxt >= 0 && nxt < modv[i]) m_cnt[i] = nxt;
                    else begin
                        hit = 1'b1;
                        if (!satv[i]) begin
                            m_cnt[i]  = (nxt + modv[i]) % modv[i];
                            m_wrap[i] = 1'b1;
                        end
                    end
                end
                m_ovf[i] = hit | (m_ovf[i] & ~ovf_clr);
            end
        end
    endtask

    task automatic model_check(input int cyc);
        int  c[3];
        bit  w[3], o[3], mx[3], mn[3];
        c  = '{int'(cnt_a), int'(cnt_b), int'(cnt_c)};
        w  = '{wrap_a, wrap_b, wrap_c};
        o  = '{ovf_a, ovf_b, ovf_c};
        mx = '{max_a, max_b, max_c};
        mn = '{min_a, min_b, min_c};
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rnd%0d_u%0d_cnt", cyc, i), c[i], m_cnt[i]);
            chk($sformatf("rnd%0d_u%0d_wrap", cyc, i), int'(w[i]), int'(m_wrap[i]));
            chk($sformatf("rnd%0d_u%0d_ovf", cyc, i), int'(o[i]), int'(m_ovf[i]));
            chk($sformatf("rnd%0d_u%0d_max", cyc, i), int'(mx[i]), int'(m_cnt[i] == modv[i] - 1));
            chk($sformatf("rnd%0d_u%0d_min", cyc, i), int'(mn[i]), int'(m_cnt[i] == 0));
        end
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0);

        // Vectors for the mod-10 wrap instance: rst en up clr ld lv oc | cnt wrap ovf
        add(1,0,0,0,0, 0,0, 0,0,0);
        add(1,0,0,0,0, 0,0, 0,0,0);
        for (int k = 1; k <= 9; k++) add(0,1,1,0,0, 0,0, k,0,0);
        add(0,1,1,0,0, 0,0, 0,1,1);
        add(0,1,1,0,0, 0,0, 1,0,1);
        add(0,1,1,0,0, 0,0, 2,0,1);
        add(0,0,0,0,0, 0,1, 2,0,0);
        add(0,0,0,0,1, 3,0, 3,0,0);
        add(0,1,0,0,0, 0,0, 2,0,0);
        add(0,1,0,0,0, 0,0, 1,0,0);
        add(0,1,0,0,0, 0,0, 0,0,0);
        add(0,1,0,0,0, 0,0, 9,1,1);
        add(0,1,0,0,0, 0,0, 8,0,1);
        add(0,0,0,0,1,15,0, 9,0,1);
        add(0,1,1,1,1, 5,0, 0,0,1);
        add(0,1,0,1,0, 0,1, 0,0,0);
        add(0,0,0,0,1, 7,0, 7,0,0);
        for (int k = 0; k < 5; k++) add(0,0,k[0],0,0, 0,0, 7,0,0);
        add(0,0,0,0,1, 9,0, 9,0,0);
        add(0,1,1,0,0, 0,1, 0,1,1);
        add(0,0,0,0,0, 0,1, 0,0,0);
        add(0,0,0,0,1, 9,0, 9,0,0);
        add(0,1,1,0,0, 0,0, 0,1,1);
        add(0,0,0,0,1, 5,0, 5,0,1);
        add(0,1,1,0,0, 0,0, 6,0,1);
        add(1,1,1,0,0, 0,0, 0,0,0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].en, tbl[i].up, tbl[i].clr, tbl[i].ld, int'(tbl[i].lv), tbl[i].oc);
            tick();
            chk($sformatf("row%0d_cnt", i), int'(cnt_a), tbl[i].ec);
            chk($sformatf("row%0d_wrap", i), int'(wrap_a), int'(tbl[i].ew));
            chk($sformatf("row%0d_ovf", i), int'(ovf_a), int'(tbl[i].eo));
            chk($sformatf("row%0d_max", i), int'(max_a), int'(tbl[i].ec == 9));
            chk($sformatf("row%0d_min", i), int'(min_a), int'(tbl[i].ec == 0));
        end

        // Saturating instance: climb into the top end and hold there.
        drive(1, 0, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 1, 8, 0); tick();
        chk("sat_load8", int'(cnt_b), 8);
        drive(0, 1, 1, 0, 0, 0, 0); tick();
        chk("sat_up1_cnt", int'(cnt_b), 9);
        chk("sat_up1_ovf", int'(ovf_b), 0);
        tick();
        chk("sat_up2_cnt", int'(cnt_b), 9);
        chk("sat_up2_wrap", int'(wrap_b), 0);
        chk("sat_up2_ovf", int'(ovf_b), 1);
        tick();
        chk("sat_up3_cnt", int'(cnt_b), 9);
        chk("sat_up3_max", int'(max_b), 1);
        drive(0, 0, 0, 0, 1, 1, 1); tick();
        chk("sat_ld1_ovfclr", int'(ovf_b), 0);
        drive(0, 1, 0, 0, 0, 0, 0); tick();
        chk("sat_dn1_cnt", int'(cnt_b), 0);
        chk("sat_dn1_ovf", int'(ovf_b), 0);
        drive(0, 1, 0, 0, 0, 0, 1); tick();
        chk("sat_dn2_cnt", int'(cnt_b), 0);
        chk("sat_dn2_wrap", int'(wrap_b), 0);
        chk("sat_dn2_ovf_set_wins", int'(ovf_b), 1);

        // Full-range instance behaves like plain 4-bit wraparound.
        drive(0, 0, 0, 0, 1, 15, 0); tick();
        chk("p2_load15", int'(cnt_c), 15);
        chk("p2_max", int'(max_c), 1);
        drive(0, 1, 1, 0, 0, 0, 0); tick();
        chk("p2_wrap_up_cnt", int'(cnt_c), 0);
        chk("p2_wrap_up_pulse", int'(wrap_c), 1);
        drive(0, 1, 0, 0, 0, 0, 0); tick();
        chk("p2_wrap_dn_cnt", int'(cnt_c), 15);
        chk("p2_wrap_dn_pulse", int'(wrap_c), 1);
        drive(0, 0, 0, 0, 0, 0, 0); tick();
        chk("p2_pulse_ends", int'(wrap_c), 0);

        // Random phase from a common reset.
        drive(1, 0, 0, 0, 0, 0, 0);
        model_step(); tick(); model_check(-1);
        for (int cyc = 0; cyc < 400; cyc++) begin
            drive($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
                  int'($urandom_range(0, 15)), $urandom_range(0, 7) == 0);
            model_step();
            tick();
            model_check(cyc);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
